// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared states, default timing and counter sizing for the PLL lock supervisor
package pll_sup_pkg;

  // Encodings are visible on state_o, so they are pinned explicitly.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_RELOCK_W      = 8;
  localparam int DEF_MAX_RETRIES   = 8;

  // Width of the shared phase counter: enough to reach the longest phase, never zero.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with synchronous clear to zero
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two back-to-back flops so the second stage has a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer and lock supervisor; PLL_SUP_RETRY_LIMIT_EN enables the retry limit and FAULT state
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RELOCK_W      = DEF_RELOCK_W,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  output logic                pll_rst,
  output logic                sys_rst_n,
  output logic                lock_lost,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic [2:0]          state_o,
  output logic                fault
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] C_RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STB_LAST = CW'(STABLE_CYCLES - 1);

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES);
  localparam logic [RW-1:0] C_RETRY_LAST = RW'(MAX_RETRIES - 1);
  logic [RW-1:0] r_retry;
  logic          r_fault;
`endif

  pll_sup_state_t        r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_pll_rst;
  logic                  r_sys_rst_n;
  logic                  r_lock_lost;
  logic [RELOCK_W-1:0]   r_relock;
  logic                  w_locked_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  // Sequencer: state, shared phase counter and all registered outputs move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_lost <= 1'b0;
      r_relock    <= '0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      r_retry     <= '0;
      r_fault     <= 1'b0;
`endif
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == C_RST_LAST) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_TO_LAST) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
`ifdef PLL_SUP_RETRY_LIMIT_EN
            if (r_retry == C_RETRY_LAST) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= ST_PLL_RST;
              r_retry <= r_retry + 1'b1;
            end
`else
            r_state <= ST_PLL_RST;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          // A drop wins over reaching the stable count; a glitch only restarts the wait.
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_STB_LAST) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
`ifdef PLL_SUP_RETRY_LIMIT_EN
            r_retry     <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_lock_lost <= 1'b1;
            if (r_relock != {RELOCK_W{1'b1}}) begin
              r_relock <= r_relock + 1'b1;
            end
          end
        end
`ifdef PLL_SUP_RETRY_LIMIT_EN
        ST_FAULT: begin
          // Held with the PLL in reset until rst_n is asserted.
        end
`endif
        default: begin
          r_state     <= ST_PLL_RST;
          r_cnt       <= '0;
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst    = r_pll_rst;
  assign sys_rst_n  = r_sys_rst_n;
  assign lock_lost  = r_lock_lost;
  assign relock_cnt = r_relock;
  assign state_o    = r_state;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  assign fault      = r_fault;
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int RELOCK_W      = 2;
  localparam int MAX_RETRIES   = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                locked = 1'b0;
  logic                pll_rst;
  logic                sys_rst_n;
  logic                lock_lost;
  logic [RELOCK_W-1:0] relock_cnt;
  logic [2:0]          state_o;
  logic                fault;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RELOCK_W      (RELOCK_W),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_lost  (lock_lost),
    .relock_cnt (relock_cnt),
    .state_o    (state_o),
    .fault      (fault)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic lk);
    rst_n  = 1'b0;
    locked = lk;
    repeat (3) tick();
    chk("rst_state", state_o, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_relock", relock_cnt, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int e_st;
    int e_pll;
    int e_sys;
    int e_ll;
    int e_rl;
    int e_flt;
    int n;

    // Lock at edge 10 -> STABLE at 13, RUN at 21; drop after edge 31 -> PLL_RST at 34.
    do_reset(1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      e_st  = (k < 4) ? 0 : (k < 13) ? 1 : (k < 21) ? 2 : (k < 34) ? 3 : (k < 38) ? 0 : 1;
      e_pll = ((k < 4) || (k >= 34 && k < 38)) ? 1 : 0;
      e_sys = (k >= 21 && k < 34) ? 1 : 0;
      e_ll  = (k == 34) ? 1 : 0;
      e_rl  = (k >= 34) ? 1 : 0;
      chk("t1_state", state_o, e_st);
      chk("t1_pll_rst", pll_rst, e_pll);
      chk("t1_sys_rst_n", sys_rst_n, e_sys);
      chk("t1_lock_lost", lock_lost, e_ll);
      chk("t1_relock", relock_cnt, e_rl);
      if (k == 10) locked = 1'b1;
      if (k == 31) locked = 1'b0;
    end

    // No lock: 4-cycle pll_rst pulse every 24 cycles, or FAULT after the 3rd timeout.
    do_reset(1'b0);
    for (int k = 1; k <= 80; k++) begin
      tick();
      e_pll = ((k < 4) || (k >= 24 && ((k - 24) % 24) < 4)) ? 1 : 0;
      e_st  = e_pll ? 0 : 1;
      e_flt = 0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      if (k >= 72) begin
        e_pll = 1;
        e_st  = 4;
        e_flt = 1;
      end
`endif
      chk("t2_state", state_o, e_st);
      chk("t2_pll_rst", pll_rst, e_pll);
      chk("t2_sys_rst_n", sys_rst_n, 0);
      chk("t2_fault", fault, e_flt);
    end

    // Glitch in STABLE: locked low over edges 16..18 -> WAIT at 18, STABLE at 21, RUN at 29.
    do_reset(1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      e_st = (k < 4) ? 0 : (k < 13) ? 1 : (k < 18) ? 2 : (k < 21) ? 1 : (k < 29) ? 2 : 3;
      chk("t3_state", state_o, e_st);
      chk("t3_pll_rst", pll_rst, (k < 4) ? 1 : 0);
      chk("t3_sys_rst_n", sys_rst_n, (k >= 29) ? 1 : 0);
      if (k == 10) locked = 1'b1;
      if (k == 15) locked = 1'b0;
      if (k == 18) locked = 1'b1;
    end

    // Four losses of lock in RUN: relock_cnt saturates at 3.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      locked = 1'b1;
      n = 0;
      while (state_o !== 3'd3 && n < 60) begin
        tick();
        n++;
      end
      chk("t5_reach_run", state_o, 3);
      tick();
      locked = 1'b0;
      n = 0;
      while (lock_lost !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("t5_lock_lost", lock_lost, 1);
      chk("t5_state", state_o, 0);
      chk("t5_relock", relock_cnt, (i < 3) ? i + 1 : 3);
      tick();
      chk("t5_pulse_width", lock_lost, 0);
    end

    // rst_n during RUN and during STABLE returns to PLL_RST on the next edge.
    locked = 1'b1;
    n = 0;
    while (state_o !== 3'd3 && n < 60) begin
      tick();
      n++;
    end
    chk("t6_reach_run", state_o, 3);
    chk("t6_relock_held", relock_cnt, 3);
    rst_n = 1'b0;
    tick();
    chk("t6_run_state", state_o, 0);
    chk("t6_run_pll_rst", pll_rst, 1);
    chk("t6_run_sys_rst_n", sys_rst_n, 0);
    chk("t6_run_relock", relock_cnt, 0);
    rst_n = 1'b1;
    n = 0;
    while (state_o !== 3'd2 && n < 60) begin
      tick();
      n++;
    end
    chk("t6_reach_stable", state_o, 2);
    rst_n = 1'b0;
    tick();
    chk("t6_stb_state", state_o, 0);
    chk("t6_stb_pll_rst", pll_rst, 1);
    chk("t6_stb_sys_rst_n", sys_rst_n, 0);
    chk("t6_stb_relock", relock_cnt, 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
